// File: rtl/poly_mod_sq_ctrl.sv
// Iteration sequencer for the polynomial modular squarer: issues T dependent squarings.
// Optional final reduce-only pass enabled by defining POLY_MOD_SQ_CTRL_FINAL_REDUCE_EN.
module poly_mod_sq_ctrl #(
   parameter int unsigned WORD_BITS       = 16,
   parameter int unsigned NUM_WORDS       = 64,
   parameter int unsigned REDUN_WORD_BITS = 1,
   parameter int unsigned I_WORD          = NUM_WORDS + 1,
   parameter int unsigned COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
   parameter int unsigned ITER_BITS       = 40,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start_val,
   output logic                           o_start_rdy,
   input  logic [I_WORD*COEF_BITS-1:0]    i_start_dat,
   input  logic [ITER_BITS-1:0]           i_iter,
   input  logic                           i_abort,
   input  logic                           i_tbl_val,
   output logic                           o_tbl_rdy,
   input  logic [NUM_WORDS*WORD_BITS-1:0] i_tbl_dat,
   output logic                           o_mul_val,
   output logic                           o_mul_reduce_only,
   output logic [I_WORD*COEF_BITS-1:0]    o_mul_dat_a,
   output logic                           o_mul_ram_we,
   output logic [NUM_WORDS*WORD_BITS-1:0] o_mul_ram_d,
   input  logic                           i_mul_val,
   input  logic [I_WORD*COEF_BITS-1:0]    i_mul_dat,
   output logic                           o_res_val,
   input  logic                           i_res_rdy,
   output logic [I_WORD*COEF_BITS-1:0]    o_res_dat,
   output logic                           o_res_err,
   output logic [ITER_BITS-1:0]           o_iter_cnt,
   output logic                           o_busy
);

   localparam int unsigned DW  = I_WORD * COEF_BITS;
   localparam int unsigned TW  = NUM_WORDS * WORD_BITS;
   localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef POLY_MOD_SQ_CTRL_FINAL_REDUCE_EN
   localparam bit FinalReduce = 1'b1;
`else
   localparam bit FinalReduce = 1'b0;
`endif

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

   state_e               state_q, state_d;
   logic [DW-1:0]        oper_q, oper_d;
   logic [ITER_BITS-1:0] remain_q, remain_d;
   logic [ITER_BITS-1:0] iter_q, iter_d;
   logic [WDW-1:0]       wdog_q, wdog_d;
   logic                 err_q, err_d;
   logic                 red_q, red_d;
   logic                 ram_we_q;
   logic [TW-1:0]        ram_d_q;
   logic                 tbl_hs;
   logic                 wdog_exp;

   always_comb begin
      state_d  = state_q;
      oper_d   = oper_q;
      remain_d = remain_q;
      iter_d   = iter_q;
      wdog_d   = wdog_q;
      err_d    = err_q;
      red_d    = red_q;
      tbl_hs   = 1'b0;
      // Watchdog counts the issue cycle too, so expiry lands TIMEOUT_CYCLES after issue.
      wdog_exp = (wdog_q == WDW'(TIMEOUT_CYCLES - 1));
      unique case (state_q)
         StIdle: begin
            tbl_hs = i_tbl_val;
            if (i_start_val && !i_tbl_val) begin
               oper_d   = i_start_dat;
               remain_d = i_iter;
               iter_d   = '0;
               err_d    = 1'b0;
               red_d    = 1'b0;
               if (i_iter != '0) begin
                  state_d = StIssue;
               end else if (FinalReduce) begin
                  state_d = StIssue;
                  red_d   = 1'b1;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StIssue: begin
            wdog_d  = WDW'(1);
            state_d = i_abort ? StIdle : StWait;
         end
         StWait: begin
            wdog_d = wdog_q + WDW'(1);
            if (i_abort) begin
               // A result arriving with the abort is already consumed; nothing to drain.
               state_d = i_mul_val ? StIdle : StDrain;
            end else if (i_mul_val) begin
               oper_d = i_mul_dat;
               if (red_q) begin
                  state_d = StDone;
               end else begin
                  iter_d   = iter_q + ITER_BITS'(1);
                  remain_d = remain_q - ITER_BITS'(1);
                  if (remain_q != ITER_BITS'(1)) begin
                     state_d = StIssue;
                  end else if (FinalReduce) begin
                     state_d = StIssue;
                     red_d   = 1'b1;
                  end else begin
                     state_d = StDone;
                  end
               end
            end else if (wdog_exp) begin
               state_d = StDone;
               err_d   = 1'b1;
            end
         end
         StDone: begin
            if (i_abort || i_res_rdy) state_d = StIdle;
         end
         StDrain: begin
            wdog_d = wdog_q + WDW'(1);
            if (i_mul_val || wdog_exp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         oper_q   <= '0;
         remain_q <= '0;
         iter_q   <= '0;
         wdog_q   <= '0;
         err_q    <= 1'b0;
         red_q    <= 1'b0;
         ram_we_q <= 1'b0;
         ram_d_q  <= '0;
      end else begin
         state_q  <= state_d;
         oper_q   <= oper_d;
         remain_q <= remain_d;
         iter_q   <= iter_d;
         wdog_q   <= wdog_d;
         err_q    <= err_d;
         red_q    <= red_d;
         ram_we_q <= tbl_hs;
         if (tbl_hs) ram_d_q <= i_tbl_dat;
      end
   end

   assign o_start_rdy = (state_q == StIdle) && !i_tbl_val;
   assign o_tbl_rdy   = (state_q == StIdle);
   assign o_mul_val   = (state_q == StIssue) && !i_abort;
   assign o_mul_dat_a = oper_q;
`ifdef POLY_MOD_SQ_CTRL_FINAL_REDUCE_EN
   assign o_mul_reduce_only = red_q;
`else
   assign o_mul_reduce_only = 1'b0;
`endif
   assign o_mul_ram_we = ram_we_q;
   assign o_mul_ram_d  = ram_d_q;
   assign o_res_val    = (state_q == StDone);
   assign o_res_dat    = oper_q;
   assign o_res_err    = (state_q == StDone) && err_q;
   assign o_iter_cnt   = iter_q;
   assign o_busy       = (state_q != StIdle);

endmodule

// File: doc/poly_mod_sq_ctrl.md
# poly_mod_sq_ctrl

Iteration sequencer for the polynomial modular squarer (multiplier instantiated with SQ_MODE=1). Accepts a redundant-form start value and an iteration count T, issues T back-to-back dependent squarings by feeding each result back as the next operand, then returns the final redundant-form result. It also owns the reduction-table write path into the multiplier's RAM and detects a stalled datapath with a watchdog.

## Interface
Parameters:
- WORD_BITS, 16, radix bits per coefficient
- NUM_WORDS, 64, coefficients in the modulus
- REDUN_WORD_BITS, 1, redundant bits per coefficient
- I_WORD, NUM_WORDS+1, operand words (derived, do not override)
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, coefficient width (derived)
- ITER_BITS, 40, width of iteration count
- TIMEOUT_CYCLES, 64, max cycles from issue to multiplier result

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start_val  in  1  start request
- o_start_rdy  out  1  start accepted when both high
- i_start_dat  in  I_WORD*COEF_BITS  initial value, redundant form
- i_iter  in  ITER_BITS  number of squarings T
- i_abort  in  1  abandon current job
- i_tbl_val  in  1  reduction-table word valid
- o_tbl_rdy  out  1  table word accepted when both high
- i_tbl_dat  in  NUM_WORDS*WORD_BITS  table word
- o_mul_val  out  1  one-cycle issue pulse to multiplier
- o_mul_reduce_only  out  1  issue is reduce-only
- o_mul_dat_a  out  I_WORD*COEF_BITS  operand to multiplier
- o_mul_ram_we  out  1  table write strobe
- o_mul_ram_d  out  NUM_WORDS*WORD_BITS  table write data
- i_mul_val  in  1  multiplier result valid
- i_mul_dat  in  I_WORD*COEF_BITS  multiplier result
- o_res_val  out  1  result valid (held until taken)
- i_res_rdy  in  1  result consumer ready
- o_res_dat  out  I_WORD*COEF_BITS  final result
- o_res_err  out  1  qualifies o_res_val: watchdog fired
- o_iter_cnt  out  ITER_BITS  squarings completed in current job
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: o_tbl_rdy=1; o_start_rdy = !i_tbl_val (table write has priority). Table handshake registers i_tbl_dat into o_mul_ram_d and pulses o_mul_ram_we next cycle.
- Start handshake: latch i_start_dat into operand register, T into remaining counter, clear o_iter_cnt. If T=0 go to DONE with result = i_start_dat; else ISSUE.
- ISSUE: pulse o_mul_val for one cycle with o_mul_dat_a = operand register, o_mul_reduce_only=0; set outstanding flag; go WAIT; clear watchdog.
- WAIT: on i_mul_val, capture i_mul_dat into operand register, increment o_iter_cnt, decrement remaining; remaining reaches 0 → DONE, else ISSUE. i_mul_val outside WAIT/DRAIN is ignored.
- Watchdog: increments each WAIT cycle; at TIMEOUT_CYCLES go DONE with o_res_err=1, o_res_dat = last operand.
- DONE: o_res_val=1, o_res_dat = operand register; leave to IDLE on i_res_rdy.
- i_abort: in ISSUE/DONE → IDLE immediately (no result). In WAIT → DRAIN; DRAIN waits for i_mul_val (discarded) or watchdog expiry, then IDLE. i_abort in IDLE ignored.
- Only one multiplication outstanding at any time.

## Timing
- Reset: all outputs 0 except o_start_rdy=1, o_tbl_rdy=1; state IDLE; counters 0.
- Start accept cycle n → o_mul_val at n+1.
- i_mul_val at cycle m → next o_mul_val at m+1 (one-cycle turnaround); final o_res_val at m+1.
- Per-iteration period = multiplier latency + 1.
- Table write: handshake at n → o_mul_ram_we at n+1.
- i_rst overrides every other input including a pending result.

## Configuration
- POLY_MOD_SQ_CTRL_FINAL_REDUCE_EN defined: after last squaring (or directly after start when T=0) one extra ISSUE with o_mul_reduce_only=1; its i_mul_val result becomes o_res_dat; o_iter_cnt not incremented for it.
- Undefined: no reduce-only pass; o_mul_reduce_only tied 0.

## Test plan
- T=3, start=1, model squarer latency 7 → three o_mul_val pulses 8 cycles apart, o_iter_cnt=3, o_res_dat = model result, o_res_err=0.
- T=0, start value X → o_res_val one cycle after accept with o_res_dat=X; no o_mul_val (macro off), one reduce-only issue (macro on).
- Model never returns i_mul_val, T=5 → o_res_val with o_res_err=1 exactly TIMEOUT_CYCLES after issue, o_iter_cnt=0.
- i_abort in WAIT with result due 3 cycles later → DRAIN, result discarded, o_busy falls the cycle after, no o_res_val.
- i_tbl_val and i_start_val together in IDLE → o_start_rdy=0, o_mul_ram_we pulses next cycle; start accepted the following cycle.
- i_res_rdy held low 10 cycles in DONE → o_res_val/o_res_dat stable; i_rst mid-WAIT → all outputs at reset values next cycle.
